// File: rtl/fifo_bulk_reader.sv
// -----------------------------------------------------------------------------
// fifo_bulk_reader
// Drains a fixed-size burst of BULK_OF_DATA words from a FIFO and presents
// them as a valid/ready stream. A burst starts only when the FIFO reports at
// least one burst worth of data and enable is high. The final beat of each
// burst is marked with m_tlast. The burst counter increments when that last
// beat is accepted.
//
// Ports
//   clk              : single clock, also the FIFO read clock
//   rst_n            : asynchronous active-low reset
//   enable           : permits a new burst (sampled only while idle)
//   fifo_r_ready     : FIFO holds at least BULK_OF_DATA words
//   fifo_error_empty : FIFO is empty
//   fifo_rdata       : FIFO read data (valid by the end of a read cycle)
//   fifo_r_enable    : FIFO read strobe, one word per high cycle
//   m_tdata          : stream data
//   m_tvalid         : stream data valid
//   m_tready         : downstream ready
//   m_tlast          : final beat of a burst
//   underflow        : sticky, set by a read issued while the FIFO is empty
//   bulk_count       : completed bursts, wraps modulo 2^32
// -----------------------------------------------------------------------------
module fifo_bulk_reader #(
    parameter int DATA_WIDTH   = 32,
    parameter int BULK_OF_DATA = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  fifo_r_ready,
    input  logic                  fifo_error_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    output logic                  fifo_r_enable,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic                  m_tlast,
    output logic                  underflow,
    output logic [31:0]           bulk_count
);

    localparam int CNT_W = $clog2(BULK_OF_DATA + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e                state_q,      state_d;
    logic [CNT_W-1:0]      cnt_q,        cnt_d;
    logic [DATA_WIDTH-1:0] m_tdata_q,    m_tdata_d;
    logic                  m_tvalid_q,   m_tvalid_d;
    logic                  m_tlast_q,    m_tlast_d;
    logic                  underflow_q,  underflow_d;
    logic [31:0]           bulk_count_q, bulk_count_d;

    logic                  rd_en_s;
    logic                  accept_s;

    // Read strobe: only while words remain and the output slot is free or
    // being emptied this cycle, so a stalled beat is never overwritten.
    always_comb begin
        accept_s = m_tvalid_q && m_tready;
        rd_en_s  = (state_q == BURST) && (cnt_q != {CNT_W{1'b0}}) &&
                   (!m_tvalid_q || m_tready);
    end

    assign fifo_r_enable = rd_en_s;
    assign m_tdata       = m_tdata_q;
    assign m_tvalid      = m_tvalid_q;
    assign m_tlast       = m_tlast_q;
    assign underflow     = underflow_q;
    assign bulk_count    = bulk_count_q;

    // Next-state logic for the burst FSM, output slot, counters and flags.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        m_tdata_d    = m_tdata_q;
        m_tvalid_d   = m_tvalid_q;
        m_tlast_d    = m_tlast_q;
        underflow_d  = underflow_q;
        bulk_count_d = bulk_count_q;

        case (state_q)
            IDLE: begin
                if (enable && fifo_r_ready) begin
                    state_d = BURST;
                    cnt_d   = CNT_W'(BULK_OF_DATA);
                end else begin
                    state_d = IDLE;
                end
            end
            BURST: begin
                // The final capture hands over to DRAIN on the same edge.
                if (rd_en_s && (cnt_q == CNT_W'(1))) begin
                    state_d = DRAIN;
                end else begin
                    state_d = BURST;
                end
            end
            DRAIN: begin
                // The only word left in the slot is the m_tlast beat.
                if (accept_s && m_tlast_q) begin
                    state_d      = IDLE;
                    bulk_count_d = bulk_count_q + 32'd1;
                end else begin
                    state_d = DRAIN;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase

        // A capture refills the slot. An accept without a refill empties it.
        if (rd_en_s) begin
            m_tdata_d  = fifo_rdata;
            m_tvalid_d = 1'b1;
            m_tlast_d  = (cnt_q == CNT_W'(1));
            cnt_d      = cnt_q - CNT_W'(1);
        end else if (accept_s) begin
            m_tvalid_d = 1'b0;
            m_tlast_d  = 1'b0;
        end else begin
            m_tvalid_d = m_tvalid_q;
        end

        // Reading an empty FIFO is latched and kept until reset.
        if (rd_en_s && fifo_error_empty) begin
            underflow_d = 1'b1;
        end else begin
            underflow_d = underflow_q;
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= {CNT_W{1'b0}};
            m_tdata_q    <= {DATA_WIDTH{1'b0}};
            m_tvalid_q   <= 1'b0;
            m_tlast_q    <= 1'b0;
            underflow_q  <= 1'b0;
            bulk_count_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            m_tdata_q    <= m_tdata_d;
            m_tvalid_q   <= m_tvalid_d;
            m_tlast_q    <= m_tlast_d;
            underflow_q  <= underflow_d;
            bulk_count_q <= bulk_count_d;
        end
    end

endmodule

// File: tb/tb_fifo_bulk_reader.sv
// -----------------------------------------------------------------------------
// tb_fifo_bulk_reader
// Scoreboard bench for fifo_bulk_reader. The FIFO is modelled as an array
// with read/write pointers. Loading words pushes the expected stream beats,
// with m_tlast on every BULK-th word, into a queue. A monitor pops and
// compares every accepted beat and also runs all other queued checks. A
// second instance with BULK_OF_DATA=1 free-runs to cover the single-word
// burst.
// -----------------------------------------------------------------------------
module tb_fifo_bulk_reader;

    localparam int DW   = 32;
    localparam int BULK = 8;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    typedef struct {
        string  name;
        longint got;
        longint exp;
    } chk_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          fifo_r_ready;
    logic          fifo_error_empty = 1'b0;
    logic [DW-1:0] fifo_rdata = '0;
    logic          fifo_r_enable;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tready = 1'b1;
    logic          m_tlast;
    logic          underflow;
    logic [31:0]   bulk_count;

    // Second instance: one word per burst.
    logic          one1 = 1'b1;
    logic          zero1 = 1'b0;
    logic [DW-1:0] rdata1 = '0;
    logic          r_enable1;
    logic [DW-1:0] tdata1;
    logic          tvalid1;
    logic          tlast1;
    logic          underflow1;
    logic [31:0]   bulk_count1;

    // FIFO model and statistics.
    logic [DW-1:0] mem [0:255];
    int            rd_cyc [0:255];
    int            beat_cyc [0:511];
    int            wr_ptr = 0;
    int            rd_ptr = 0;
    int            force_idx = -1;
    int            cyc = 0;
    int            beat_cnt = 0;
    int            exp_pos = 0;
    int            exp_bulk = 0;
    int            tready_mode = 0;
    int            n_tests = 0;
    int            n_fail = 0;

    beat_t exp_q[$];
    chk_t  chk_q[$];

    assign fifo_r_ready = ((wr_ptr - rd_ptr) >= BULK);

    fifo_bulk_reader #(.DATA_WIDTH(DW), .BULK_OF_DATA(BULK)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .fifo_r_ready(fifo_r_ready),
        .fifo_error_empty(fifo_error_empty), .fifo_rdata(fifo_rdata),
        .fifo_r_enable(fifo_r_enable), .m_tdata(m_tdata), .m_tvalid(m_tvalid),
        .m_tready(m_tready), .m_tlast(m_tlast), .underflow(underflow),
        .bulk_count(bulk_count)
    );

    fifo_bulk_reader #(.DATA_WIDTH(DW), .BULK_OF_DATA(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .enable(one1), .fifo_r_ready(one1),
        .fifo_error_empty(zero1), .fifo_rdata(rdata1),
        .fifo_r_enable(r_enable1), .m_tdata(tdata1), .m_tvalid(tvalid1),
        .m_tready(one1), .m_tlast(tlast1), .underflow(underflow1),
        .bulk_count(bulk_count1)
    );

    always #5 clk = ~clk;

    // Cycle counter, advanced on every rising edge.
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // FIFO read side: new word on the falling edge of a read cycle. A forced
    // empty read discards the word and leaves the old data on the bus.
    initial forever begin
        @(negedge clk);
        if (fifo_r_enable) begin
            rd_cyc[rd_ptr & 255] = cyc;
            if (rd_ptr == force_idx) begin
                fifo_error_empty = 1'b1;
            end else begin
                fifo_error_empty = 1'b0;
                fifo_rdata       = mem[rd_ptr & 255];
            end
            rd_ptr++;
        end else begin
            fifo_error_empty = 1'b0;
        end
        if (r_enable1) rdata1 = rdata1 + 32'd1;
    end

    // Downstream ready pattern: 0 always, 1 toggling, 2 random.
    initial forever begin
        @(posedge clk);
        #1;
        case (tready_mode)
            1:       m_tready = ~m_tready;
            2:       m_tready = 1'($urandom_range(1, 0));
            default: m_tready = 1'b1;
        endcase
    end

    // Monitor: runs queued checks, compares accepted beats, checks stalls.
    initial begin
        chk_t          c;
        beat_t         b;
        logic          hold_prev = 1'b0;
        logic [DW-1:0] prev_data = '0;
        logic          prev_last = 1'b0;
        forever begin
            @(negedge clk);
            while (chk_q.size() > 0) begin
                c = chk_q.pop_front();
                n_tests++;
                if (c.got != c.exp) begin
                    n_fail++;
                    $display("FAIL %s: got 0x%0h, expected 0x%0h", c.name, c.got, c.exp);
                end
            end
            if (rst_n) begin
                if (hold_prev) begin
                    n_tests++;
                    if (!m_tvalid || m_tdata !== prev_data || m_tlast !== prev_last) begin
                        n_fail++;
                        $display("FAIL stall_hold: got v=%b d=0x%0h l=%b, expected v=1 d=0x%0h l=%b",
                                 m_tvalid, m_tdata, m_tlast, prev_data, prev_last);
                    end
                end
                if (m_tvalid && !m_tready) begin
                    n_tests++;
                    if (fifo_r_enable) begin
                        n_fail++;
                        $display("FAIL rd_while_stalled: got fifo_r_enable=1, expected 0");
                    end
                end
                if (m_tvalid && m_tready) begin
                    beat_cyc[beat_cnt & 511] = cyc;
                    beat_cnt++;
                    n_tests++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL beat_unexpected: got data 0x%0h, expected no beat", m_tdata);
                    end else begin
                        b = exp_q.pop_front();
                        if (m_tdata !== b.data || m_tlast !== b.last) begin
                            n_fail++;
                            $display("FAIL beat_%0d: got data 0x%0h last %b, expected data 0x%0h last %b",
                                     beat_cnt, m_tdata, m_tlast, b.data, b.last);
                        end
                    end
                end
                hold_prev = m_tvalid && !m_tready;
                prev_data = m_tdata;
                prev_last = m_tlast;
                if (tvalid1) begin
                    n_tests++;
                    if (tlast1 !== 1'b1 || tdata1 == '0) begin
                        n_fail++;
                        $display("FAIL bulk1_beat: got last %b data 0x%0h, expected last 1 data nonzero",
                                 tlast1, tdata1);
                    end
                end
            end else begin
                hold_prev = 1'b0;
            end
        end
    end

    task automatic chk(input string name, input longint got, input longint exp);
        chk_q.push_back('{name, got, exp});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Put n words in the FIFO and queue the stream beats they must produce.
    task automatic load(input int n, input bit rnd);
        beat_t         b;
        logic [DW-1:0] w;
        for (int i = 0; i < n; i++) begin
            w = rnd ? DW'($urandom) : DW'(i + 1);
            mem[(wr_ptr + i) & 255] = w;
            b.data = ((wr_ptr + i) == force_idx) ? mem[(wr_ptr + i - 1) & 255] : w;
            exp_pos++;
            b.last = (exp_pos == BULK);
            if (b.last) exp_pos = 0;
            exp_q.push_back(b);
        end
        wr_ptr = wr_ptr + n;
    endtask

    task automatic wait_beats(input int target, input int budget);
        int k = 0;
        while (beat_cnt < target && k < budget) begin
            tick();
            k++;
        end
        chk("beats_done", beat_cnt, target);
    endtask

    task automatic wait_reads(input int target);
        int k = 0;
        while (rd_ptr < target && k < 60) begin
            tick();
            k++;
        end
        chk("reads_reached", (rd_ptr >= target) ? 1 : 0, 1);
    endtask

    // One-cycle enable pulse, then run the burst to completion.
    task automatic run_burst(input int budget);
        int bs = beat_cnt;
        enable = 1'b1;
        tick();
        enable = 1'b0;
        wait_beats(bs + BULK, budget);
        tick();
        tick();
        exp_bulk++;
        chk("bulk_count", bulk_count, exp_bulk);
        chk("sb_empty", exp_q.size(), 0);
    endtask

    initial begin
        int s, bs, n0;

        // Reset values.
        tick();
        chk("rst_tvalid", m_tvalid, 0);
        chk("rst_tdata", m_tdata, 0);
        chk("rst_rd_en", fifo_r_enable, 0);
        chk("rst_bulk", bulk_count, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // enable low with a full FIFO: nothing is read.
        load(BULK, 1'b0);
        s = rd_ptr;
        repeat (20) tick();
        chk("no_read_when_disabled", rd_ptr, s);

        // Words 1..8, ready high: latency, no-gap reads, data and m_tlast.
        s  = rd_ptr;
        bs = beat_cnt;
        n0 = cyc;
        enable = 1'b1;
        tick();
        enable = 1'b0;
        wait_beats(bs + BULK, 40);
        chk("first_read_cycle", rd_cyc[s & 255], n0 + 1);
        chk("read_span", rd_cyc[(s + 7) & 255] - rd_cyc[s & 255], 7);
        chk("first_valid_cycle", beat_cyc[bs & 511], n0 + 2);
        tick();
        tick();
        exp_bulk++;
        chk("bulk_count", bulk_count, exp_bulk);

        // Toggling ready.
        tready_mode = 1;
        load(BULK, 1'b0);
        run_burst(60);
        tready_mode = 0;

        // enable dropped mid-burst.
        load(BULK, 1'b1);
        s  = rd_ptr;
        bs = beat_cnt;
        enable = 1'b1;
        wait_reads(s + 3);
        enable = 1'b0;
        wait_beats(bs + BULK, 40);
        tick();
        tick();
        exp_bulk++;
        chk("bulk_after_enable_drop", bulk_count, exp_bulk);
        chk("reads_after_enable_drop", rd_ptr - s, BULK);

        // Empty FIFO on the 5th read: sticky underflow, stale data.
        chk("underflow_clear", underflow, 0);
        force_idx = wr_ptr + 4;
        load(BULK, 1'b1);
        run_burst(40);
        force_idx = -1;
        chk("underflow_set", underflow, 1);
        tready_mode = 2;
        load(BULK, 1'b1);
        run_burst(80);
        tready_mode = 0;
        chk("underflow_sticky", underflow, 1);

        // Three back-to-back bursts with enable held.
        load(3 * BULK, 1'b0);
        bs = beat_cnt;
        enable = 1'b1;
        wait_beats(bs + 3 * BULK, 80);
        enable = 1'b0;
        tick();
        tick();
        exp_bulk += 3;
        chk("bulk_after_three", bulk_count, exp_bulk);
        chk("sb_empty_three", exp_q.size(), 0);

        // Asynchronous reset after the 3rd read.
        load(BULK, 1'b1);
        s = rd_ptr;
        enable = 1'b1;
        wait_reads(s + 3);
        enable = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_tvalid", m_tvalid, 0);
        chk("arst_tlast", m_tlast, 0);
        chk("arst_tdata", m_tdata, 0);
        chk("arst_rd_en", fifo_r_enable, 0);
        chk("arst_underflow", underflow, 0);
        chk("arst_bulk", bulk_count, 0);
        exp_q.delete();
        exp_pos  = 0;
        exp_bulk = 0;
        wr_ptr   = rd_ptr;
        tick();
        tick();
        rst_n = 1'b1;
        s = rd_ptr;
        enable = 1'b1;
        repeat (5) tick();
        chk("no_read_fifo_not_ready", rd_ptr, s);
        enable = 1'b0;
        load(BULK, 1'b1);
        run_burst(40);
        chk("underflow_after_reset", underflow, 0);

        // Randomized bursts: random data, ready pattern and idle gaps.
        tready_mode = 2;
        for (int i = 0; i < 4; i++) begin
            load(BULK, 1'b1);
            repeat ($urandom_range(4, 0)) tick();
            run_burst(100);
        end
        tready_mode = 0;

        chk("bulk1_active", (bulk_count1 != 32'd0) ? 1 : 0, 1);
        chk("bulk1_underflow", underflow1, 0);
        tick();
        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_bulk_reader.md
FIFO_BULK_READER -- requirements
Module: fifo_bulk_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of FIFO read data and stream data.
REQ-002 SHALL have parameter BULK_OF_DATA, default 8: number of words drained per burst; legal range ≥1.
REQ-003 SHALL have port clk  input  1: single clock; also drives the FIFO read clock.
REQ-004 SHALL have port rst_n  input  1: one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port enable  input  1: permits starting a new burst.
REQ-006 SHALL have port fifo_r_ready  input  1: FIFO holds at least BULK_OF_DATA words.
REQ-007 SHALL have port fifo_error_empty  input  1: FIFO is empty.
REQ-008 SHALL have port fifo_rdata  input  DATA_WIDTH: FIFO read data, updated on the falling clk edge of a cycle with fifo_r_enable high.
REQ-009 SHALL have port fifo_r_enable  output  1: FIFO read strobe, one word per cycle high.
REQ-010 SHALL have port m_tdata  output  DATA_WIDTH: stream data.
REQ-011 SHALL have port m_tvalid  output  1: stream data valid.
REQ-012 SHALL have port m_tready  input  1: downstream accepts a beat when m_tvalid and m_tready are both high at a rising edge.
REQ-013 SHALL have port m_tlast  output  1: marks the final beat of a burst.
REQ-014 SHALL have port underflow  output  1: sticky flag for a read issued while the FIFO is empty.
REQ-015 SHALL have port bulk_count  output  32: number of completed bursts, wrapping modulo 2^32.

Function
REQ-016 SHALL implement states IDLE, BURST and DRAIN.
REQ-017 In IDLE, SHALL move to BURST at a rising edge where enable=1 and fifo_r_ready=1; otherwise SHALL stay in IDLE.
REQ-018 SHALL load the read counter with BULK_OF_DATA on entry to BURST.
REQ-019 SHALL drive fifo_r_enable combinationally = (state==BURST) && (counter>0) && (!m_tvalid || m_tready).
REQ-020 At each rising edge with fifo_r_enable=1, SHALL capture fifo_rdata into m_tdata, set m_tvalid=1 and decrement the counter.
REQ-021 SHALL set m_tlast=1 together with the word captured when the counter goes from 1 to 0; otherwise SHALL set m_tlast=0 on each capture.
REQ-022 At a rising edge with an accepted beat and no new capture, SHALL clear m_tvalid and m_tlast.
REQ-023 SHALL hold m_tdata, m_tvalid and m_tlast stable while m_tvalid=1 and m_tready=0.
REQ-024 SHALL move from BURST to DRAIN on the edge of the final capture.
REQ-025 SHALL move from DRAIN to IDLE when the m_tlast beat is accepted, and SHALL increment bulk_count by 1 on that same edge.
REQ-026 Latency: if the IDLE->BURST edge is edge k, the first fifo_r_enable SHALL occur in cycle k+1 and the first m_tvalid in cycle k+2.
REQ-027 Throughput: with m_tready held at 1, a burst SHALL take BULK_OF_DATA consecutive read cycles with no gaps.
REQ-028 The earliest next IDLE->BURST transition SHALL be the edge after DRAIN exits; bursts SHALL never overlap.
REQ-029 SHALL sample enable only in IDLE; deasserting enable mid-burst SHALL NOT abort or shorten the burst.
REQ-030 SHALL set underflow=1 if fifo_r_enable=1 and fifo_error_empty=1 at a rising edge; the burst SHALL continue with the stale data.
REQ-031 underflow SHALL stay set until reset.
REQ-032 The read counter SHALL be sized ceil(log2(BULK_OF_DATA+1)) bits.
REQ-033 With BULK_OF_DATA=1, the single word SHALL carry m_tlast=1.

Reset
REQ-034 On rst_n=0, regardless of clk, SHALL force state=IDLE, counter=0, m_tdata=0, m_tvalid=0, m_tlast=0, underflow=0 and bulk_count=0.
REQ-035 fifo_r_enable SHALL be 0 while rst_n=0.
REQ-036 Reset asserted mid-burst SHALL abandon the burst with no further reads; words already taken from the FIFO are lost.
REQ-037 After rst_n deasserts, the first state transition SHALL occur no earlier than the first rising edge.

Verification
REQ-038 Scenario: BULK_OF_DATA=8, FIFO preloaded with 1..8, enable=1, m_tready=1 -> 8 consecutive fifo_r_enable cycles; m_tdata 1..8; m_tlast only on 8; bulk_count=1.
REQ-039 Scenario: same preload, m_tready toggled 1,0,1,0... -> no word lost or duplicated; fifo_r_enable never high when m_tvalid=1 and m_tready=0; output 1..8.
REQ-040 Scenario: enable=0 with fifo_r_ready=1 for 20 cycles -> fifo_r_enable stays 0; enable dropped in cycle 3 of a burst -> all 8 words still delivered.
REQ-041 Scenario: rst_n pulsed low asynchronously after the 3rd read -> all outputs 0 immediately, state IDLE; next burst starts only after fifo_r_ready=1.
REQ-042 Scenario: fifo_error_empty forced to 1 during the 5th read -> underflow=1 and stays 1 through further bursts until reset.
REQ-043 Scenario: 3 back-to-back bursts with fifo_r_ready held high -> bulk_count=3; exactly 24 beats; m_tlast on beats 8, 16 and 24.
